// File: rtl/core_result_merger.sv
// Merges per-core best-match results (SAD, v0, v1) into one minimum-SAD result
// using a raster-order tie-break; cores hand over results via valid/ack.
//
// state      | meaning
// ST_COLLECT | accepting one pending core result per cycle, lowest index first
// ST_DONE    | every core merged, out_v0/out_v1 final, valids ignored
module core_result_merger #(
   parameter int NUM_CORES = 2,
   parameter int SAD_W     = 32
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       start,
   input  logic [NUM_CORES-1:0]       res_valid,
   input  logic [NUM_CORES*SAD_W-1:0] res_sad,
   input  logic [NUM_CORES*32-1:0]    res_v0,
   input  logic [NUM_CORES*32-1:0]    res_v1,
   output logic [NUM_CORES-1:0]       res_ack,
   output logic [31:0]                out_v0,
   output logic [31:0]                out_v1,
   output logic                       out_done
);

   typedef enum logic {ST_COLLECT = 1'b0, ST_DONE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [NUM_CORES-1:0]   got_q, got_d;
   logic                   have_best_q, have_best_d;
   logic [SAD_W-1:0]       best_sad_q, best_sad_d;
   logic [31:0]            best_v0_q, best_v0_d;
   logic [31:0]            best_v1_q, best_v1_d;
   logic [31:0]            out_v0_q, out_v0_d;
   logic [31:0]            out_v1_q, out_v1_d;
   logic                   out_done_q, out_done_d;

   logic [NUM_CORES-1:0]   grant;
   logic                   found;
   logic                   accept;
   logic                   all_got;
   logic                   replace;
   logic [SAD_W-1:0]       cand_sad;
   logic [31:0]            cand_v0;
   logic [31:0]            cand_v1;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_COLLECT;
      end else if (state_q == ST_COLLECT && accept && all_got) begin
         state_d = ST_DONE;
      end
   end

   // Acks are suppressed while reset is held so no core believes it was taken.
   always_comb begin
      res_ack = '0;
      if (Reset && state_q == ST_COLLECT && !start) begin
         res_ack = grant;
      end
   end

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!found && res_valid[i] && !got_q[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign accept  = |res_ack;
   assign all_got = &(got_q | res_ack);

   always_comb begin
      cand_sad = '0;
      cand_v0  = '0;
      cand_v1  = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (res_ack[i]) begin
            cand_sad = res_sad[i*SAD_W +: SAD_W];
            cand_v0  = res_v0[i*32 +: 32];
            cand_v1  = res_v1[i*32 +: 32];
         end
      end
   end

   // Total order on (sad, v0, v1) makes the merge independent of arrival order.
   always_comb begin
      replace = 1'b0;
      if (!have_best_q) begin
         replace = 1'b1;
      end else if (cand_sad < best_sad_q) begin
         replace = 1'b1;
      end else if (cand_sad == best_sad_q && cand_v0 < best_v0_q) begin
         replace = 1'b1;
      end else if (cand_sad == best_sad_q && cand_v0 == best_v0_q && cand_v1 < best_v1_q) begin
         replace = 1'b1;
      end
   end

   always_comb begin
      got_d       = got_q;
      have_best_d = have_best_q;
      best_sad_d  = best_sad_q;
      best_v0_d   = best_v0_q;
      best_v1_d   = best_v1_q;
      out_v0_d    = out_v0_q;
      out_v1_d    = out_v1_q;
      out_done_d  = out_done_q;
      if (start) begin
         got_d       = '0;
         have_best_d = 1'b0;
         best_sad_d  = '0;
         best_v0_d   = '0;
         best_v1_d   = '0;
         out_v0_d    = '0;
         out_v1_d    = '0;
         out_done_d  = 1'b0;
      end else if (accept) begin
         got_d = got_q | res_ack;
         if (replace) begin
            have_best_d = 1'b1;
            best_sad_d  = cand_sad;
            best_v0_d   = cand_v0;
            best_v1_d   = cand_v1;
         end
         if (all_got) begin
            out_v0_d   = best_v0_d;
            out_v1_d   = best_v1_d;
            out_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         got_q       <= '0;
         have_best_q <= 1'b0;
         best_sad_q  <= '0;
         best_v0_q   <= '0;
         best_v1_q   <= '0;
         out_v0_q    <= '0;
         out_v1_q    <= '0;
         out_done_q  <= 1'b0;
      end else begin
         got_q       <= got_d;
         have_best_q <= have_best_d;
         best_sad_q  <= best_sad_d;
         best_v0_q   <= best_v0_d;
         best_v1_q   <= best_v1_d;
         out_v0_q    <= out_v0_d;
         out_v1_q    <= out_v1_d;
         out_done_q  <= out_done_d;
      end
   end

   assign out_v0   = out_v0_q;
   assign out_v1   = out_v1_q;
   assign out_done = out_done_q;

endmodule

// File: tb/tb_core_result_merger.sv
// Directed bench for core_result_merger with two cores: a table of merge rounds
// plus hand-written late-arrival, hold-valid, reset and restart sequences.
module tb_core_result_merger;

   logic          Clk;
   logic          Reset;
   logic          start;
   logic [1:0]    res_valid;
   logic [63:0]   res_sad;
   logic [63:0]   res_v0;
   logic [63:0]   res_v1;
   logic [1:0]    res_ack;
   logic [31:0]   out_v0;
   logic [31:0]   out_v1;
   logic          out_done;

   int n_checks;
   int n_errors;

   core_result_merger #(.NUM_CORES(2), .SAD_W(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .start     (start),
      .res_valid (res_valid),
      .res_sad   (res_sad),
      .res_v0    (res_v0),
      .res_v1    (res_v1),
      .res_ack   (res_ack),
      .out_v0    (out_v0),
      .out_v1    (out_v1),
      .out_done  (out_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic [31:0] sad0, v00, v10;
      logic [31:0] sad1, v01, v11;
      logic [31:0] ev0, ev1;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_data(input logic [31:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] s1, input logic [31:0] a1, input logic [31:0] b1);
      res_sad = {s1, s0};
      res_v0  = {a1, a0};
      res_v1  = {b1, b0};
   endtask

   // Drive just after the rising edge, then wait to mid-cycle for sampling.
   task automatic step(input logic s, input logic [1:0] v);
      @(posedge Clk);
      #1;
      start     = s;
      res_valid = v;
      @(negedge Clk);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_done"}, {31'd0, out_done}, 32'd0);
      chk({name, "_v0"}, out_v0, 32'd0);
      chk({name, "_v1"}, out_v1, 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      Reset     = 1'b0;
      start     = 1'b0;
      res_valid = 2'b00;
      set_data(0, 0, 0, 0, 0, 0);

      vecs[0] = '{"plan_basic",   40, 3, 5,             25, 9, 1,             9, 1};
      vecs[1] = '{"tie_v1",       10, 4, 7,             10, 4, 2,             4, 2};
      vecs[2] = '{"tie_v1_swap",  10, 4, 2,             10, 4, 7,             4, 2};
      vecs[3] = '{"tie_v0",        8, 1, 0,              8, 0, 9,             0, 9};
      vecs[4] = '{"sad_msb",      32'hFFFF_FFFF, 1, 1,  32'hFFFF_FFFE, 2, 2,  2, 2};
      vecs[5] = '{"identical",     5, 6, 7,              5, 6, 7,             6, 7};
      vecs[6] = '{"sad_zero",      0, 7, 7,              1, 0, 0,             7, 7};
      vecs[7] = '{"v0_msb",        5, 32'h8000_0000, 0,  5, 1, 3,             1, 3};

      repeat (4) @(posedge Clk);
      @(negedge Clk);
      chk_idle("reset");
      chk("reset_ack", {30'd0, res_ack}, 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         if (i != 0) begin
            step(1'b1, 2'b00);
            chk({vecs[i].name, "_start_ack"}, {30'd0, res_ack}, 32'd0);
         end
         set_data(vecs[i].sad0, vecs[i].v00, vecs[i].v10, vecs[i].sad1, vecs[i].v01, vecs[i].v11);
         step(1'b0, 2'b11);
         chk({vecs[i].name, "_ack_c0"}, {30'd0, res_ack}, 32'd1);
         chk_idle({vecs[i].name, "_c0"});
         step(1'b0, 2'b11);
         chk({vecs[i].name, "_ack_c1"}, {30'd0, res_ack}, 32'd2);
         chk_idle({vecs[i].name, "_c1"});
         step(1'b0, 2'b11);
         chk({vecs[i].name, "_done_ack"}, {30'd0, res_ack}, 32'd0);
         chk({vecs[i].name, "_done"}, {31'd0, out_done}, 32'd1);
         chk({vecs[i].name, "_v0"}, out_v0, vecs[i].ev0);
         chk({vecs[i].name, "_v1"}, out_v1, vecs[i].ev1);
      end

      // Core1 arrives five cycles before core0.
      step(1'b1, 2'b00);
      set_data(8, 0, 6, 8, 1, 4);
      step(1'b0, 2'b10);
      chk("late_ack1", {30'd0, res_ack}, 32'd2);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 2'b10);
         chk("late_wait_ack", {30'd0, res_ack}, 32'd0);
         chk_idle("late_wait");
      end
      step(1'b0, 2'b11);
      chk("late_ack0", {30'd0, res_ack}, 32'd1);
      chk_idle("late_pre");
      step(1'b0, 2'b00);
      chk("late_done", {31'd0, out_done}, 32'd1);
      chk("late_v0", out_v0, 32'd0);
      chk("late_v1", out_v1, 32'd6);

      // Core0 keeps valid high after its ack while core1 is late.
      step(1'b1, 2'b00);
      set_data(20, 3, 3, 30, 1, 1);
      step(1'b0, 2'b01);
      chk("hold_ack0", {30'd0, res_ack}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'b01);
         chk("hold_no_reack", {30'd0, res_ack}, 32'd0);
         chk("hold_done", {31'd0, out_done}, 32'd0);
      end
      step(1'b0, 2'b11);
      chk("hold_ack1", {30'd0, res_ack}, 32'd2);
      step(1'b0, 2'b00);
      chk("hold_done_final", {31'd0, out_done}, 32'd1);
      chk("hold_v0", out_v0, 32'd3);
      chk("hold_v1", out_v1, 32'd3);

      // Asynchronous reset while DONE: outputs clear without a clock edge.
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      #1;
      chk_idle("async_done");
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // Reset mid-round after only core0 was accepted.
      set_data(15, 2, 2, 12, 5, 5);
      step(1'b0, 2'b01);
      chk("mid_ack0", {30'd0, res_ack}, 32'd1);
      @(posedge Clk);
      #1;
      res_valid = 2'b11;
      #2;
      Reset = 1'b0;
      #1;
      chk_idle("mid_async");
      chk("mid_async_ack", {30'd0, res_ack}, 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(negedge Clk);
      chk("mid_reack0", {30'd0, res_ack}, 32'd1);
      step(1'b0, 2'b11);
      chk("mid_reack1", {30'd0, res_ack}, 32'd2);
      step(1'b0, 2'b11);
      chk("mid_done", {31'd0, out_done}, 32'd1);
      chk("mid_v0", out_v0, 32'd5);
      chk("mid_v1", out_v1, 32'd5);

      // Restart from DONE with both valids high and new data.
      set_data(1, 8, 8, 2, 0, 0);
      step(1'b1, 2'b11);
      chk("restart_no_ack", {30'd0, res_ack}, 32'd0);
      step(1'b0, 2'b11);
      chk_idle("restart_clear");
      chk("restart_ack0", {30'd0, res_ack}, 32'd1);
      step(1'b0, 2'b11);
      chk("restart_ack1", {30'd0, res_ack}, 32'd2);
      step(1'b0, 2'b00);
      chk("restart_done", {31'd0, out_done}, 32'd1);
      chk("restart_v0", out_v0, 32'd8);
      chk("restart_v1", out_v1, 32'd8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
